// File: rtl/matmul_sequencer.sv
// matmul_sequencer: load/compute/output control for an NxN systolic MMU.
// Ports: clk, rst_n (async, active-low), start, host_valid, host_req_mat,
//   wm_load_mat, wm_addr, feeding_en, mmu_cycles, out_valid, out_idx,
//   busy, done; reuse_w only when MATMUL_SEQ_REUSE_EN is defined.
module matmul_sequencer #(
  parameter int N  = 2,
  parameter int AW = 3,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          host_valid,
  output logic          host_req_mat,
  output logic          wm_load_mat,
  output logic [AW-1:0] wm_addr,
  output logic          feeding_en,
  output logic [CW-1:0] mmu_cycles,
  output logic          out_valid,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done
`ifdef MATMUL_SEQ_REUSE_EN
  ,
  input  logic          reuse_w
`endif
);

  localparam int NN = N * N;
  localparam logic [AW-1:0] LAST_ADDR = AW'(2 * NN - 1);
  localparam logic [AW-1:0] ACT_BASE  = AW'(NN);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NN - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(3 * N - 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [AW-1:0] base;

`ifdef MATMUL_SEQ_REUSE_EN
  logic wv_q, wv_d;

  // Skip the weight half only when a previous full load left it valid.
  assign base = (reuse_w && wv_q) ? ACT_BASE : '0;
`else
  assign base = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      cyc_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
`ifdef MATMUL_SEQ_REUSE_EN
      wv_q   <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      cyc_q  <= cyc_d;
      idx_q  <= idx_d;
      done_q <= done_d;
`ifdef MATMUL_SEQ_REUSE_EN
      wv_q   <= wv_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef MATMUL_SEQ_REUSE_EN
    wv_d    = wv_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = base;
        end
      end
      LOAD: begin
        if (host_valid) begin
          if (addr_q == LAST_ADDR) begin
            state_d = COMPUTE;
            addr_d  = '0;
`ifdef MATMUL_SEQ_REUSE_EN
            wv_d    = 1'b1;
`endif
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      COMPUTE: begin
        if (cyc_q == LAST_CYC) begin
          state_d = OUTPUT;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      OUTPUT: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters are zero outside their own state, so the
  // count outputs are zero there without extra gating.
  assign host_req_mat = (state == LOAD);
  assign wm_load_mat  = host_req_mat & host_valid;
  assign wm_addr      = addr_q;
  assign feeding_en   = (state == COMPUTE);
  assign mmu_cycles   = cyc_q;
  assign out_valid    = (state == OUTPUT);
  assign out_idx      = idx_q;
  assign busy         = (state != IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=2 scoreboard of timed events
// plus an N=4 instance checked by running counts.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start4 = 1'b0;
  logic host_valid = 1'b1;
`ifdef MATMUL_SEQ_REUSE_EN
  logic reuse_w = 1'b0;
`endif

  logic       hrq, wl, fe, ov, busy, done;
  logic [2:0] wa, mc, oi;
  logic       hrq4, wl4, fe4, ov4, busy4, done4;
  logic [4:0] wa4, oi4;
  logic [3:0] mc4;

  matmul_sequencer #(.N(2), .AW(3), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .host_valid(host_valid), .host_req_mat(hrq),
    .wm_load_mat(wl), .wm_addr(wa), .feeding_en(fe),
    .mmu_cycles(mc), .out_valid(ov), .out_idx(oi),
    .busy(busy), .done(done)
`ifdef MATMUL_SEQ_REUSE_EN
    , .reuse_w(reuse_w)
`endif
  );

  matmul_sequencer #(.N(4), .AW(5), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .host_valid(host_valid), .host_req_mat(hrq4),
    .wm_load_mat(wl4), .wm_addr(wa4), .feeding_en(fe4),
    .mmu_cycles(mc4), .out_valid(ov4), .out_idx(oi4),
    .busy(busy4), .done(done4)
`ifdef MATMUL_SEQ_REUSE_EN
    , .reuse_w(reuse_w)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int v;
  } ev_t;

  ev_t q_wr[$];
  ev_t q_fe[$];
  ev_t q_out[$];
  ev_t q_done[$];

  int checks = 0;
  int errors = 0;

  task automatic cmp(string nm, int gc, int ec, int gv, int ev);
    checks++;
    if (gc != ec || gv != ev) begin
      errors++;
      $display("FAIL %s: got cycle %0d value %0d, expected cycle %0d value %0d",
               nm, gc, gv, ec, ev);
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic unexp(string nm, int c, int v);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event cycle %0d value %0d", nm, c, v);
  endtask

  // Scoreboard monitor for the N=2 instance.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (wl) begin
        if (q_wr.size() == 0) unexp("wr", cyc, int'(wa));
        else begin
          e = q_wr.pop_front();
          cmp("wr", cyc, e.c, int'(wa), e.v);
        end
      end
      if (fe) begin
        if (q_fe.size() == 0) unexp("feed", cyc, int'(mc));
        else begin
          e = q_fe.pop_front();
          cmp("feed", cyc, e.c, int'(mc), e.v);
        end
      end
      if (ov) begin
        if (q_out.size() == 0) unexp("out", cyc, int'(oi));
        else begin
          e = q_out.pop_front();
          cmp("out", cyc, e.c, int'(oi), e.v);
        end
      end
      if (done) begin
        if (q_done.size() == 0) unexp("done", cyc, 1);
        else begin
          e = q_done.pop_front();
          cmp("done", cyc, e.c, 1, e.v);
        end
      end
    end
  end

  int w4 = 0;
  int f4 = 0;
  int o4 = 0;
  int d4c = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wl4) begin
        chk("n4 wr addr", int'(wa4), w4);
        w4++;
      end
      if (fe4) begin
        chk("n4 mmu_cycles", int'(mc4), f4);
        f4++;
      end
      if (ov4) begin
        chk("n4 out_idx", int'(oi4), o4);
        o4++;
      end
      if (done4) d4c = cyc;
    end
  end

  // Expected N=2 job: start seen in cycle t0, loading from
  // address 'first', with sl stall cycles after sa accepts.
  task automatic push_job(int t0, int first, int sa, int sl);
    ev_t e;
    int  l;
    int  le;
    l = 8 - first;
    for (int k = 0; k < l; k++) begin
      e.c = t0 + 1 + k + ((k >= sa) ? sl : 0);
      e.v = first + k;
      q_wr.push_back(e);
    end
    le = t0 + l + sl;
    for (int i = 0; i < 5; i++) begin
      e.c = le + 1 + i;
      e.v = i;
      q_fe.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      e.c = le + 6 + i;
      e.v = i;
      q_out.push_back(e);
    end
    e.c = le + 10;
    e.v = 1;
    q_done.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    return q_wr.size() + q_fe.size() + q_out.size() + q_done.size();
  endfunction

  task automatic wait_idle(string nm);
    for (int i = 0; i < 300; i++) begin
      if (pending() == 0) break;
      step();
    end
    chk({nm, " pending events"}, pending(), 0);
    step();
    chk({nm, " idle busy"}, int'(busy), 0);
  endtask

  task automatic check_zero(string nm);
    chk({nm, " host_req_mat"}, int'(hrq), 0);
    chk({nm, " wm_load_mat"}, int'(wl), 0);
    chk({nm, " wm_addr"}, int'(wa), 0);
    chk({nm, " feeding_en"}, int'(fe), 0);
    chk({nm, " mmu_cycles"}, int'(mc), 0);
    chk({nm, " out_valid"}, int'(ov), 0);
    chk({nm, " out_idx"}, int'(oi), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    #1;
    check_zero("reset");
    chk("reset n4 busy", int'(busy4), 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full job, stray start in LOAD, start held through done.
    t0 = cyc;
    start = 1'b1;
    push_job(t0, 0, 8, 0);
    step();
    start = 1'b0;
    chk("start latency busy", int'(busy), 1);
    chk("start latency host_req", int'(hrq), 1);
    while (cyc < t0 + 5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t0 + 17) step();
    start = 1'b1;
    push_job(t0 + 18, 0, 8, 0);
    step();
    step();
    start = 1'b0;
    chk("back-to-back host_req", int'(hrq), 1);
    wait_idle("back-to-back");

    // Host stalls for 3 cycles after the second accept.
    t0 = cyc;
    start = 1'b1;
    push_job(t0, 0, 2, 3);
    step();
    start = 1'b0;
    step();
    step();
    host_valid = 1'b0;
    step();
    step();
    step();
    host_valid = 1'b1;
    wait_idle("stall");

    // N=4 instance.
    t0 = cyc;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk("n4 start host_req", int'(hrq4), 1);
    for (int i = 0; i < 200; i++) begin
      if (d4c >= 0) break;
      step();
    end
    chk("n4 done cycle", d4c, t0 + 60);
    chk("n4 writes", w4, 32);
    chk("n4 compute cycles", f4, 11);
    chk("n4 outputs", o4, 16);
    step();
    chk("n4 idle", int'(busy4 | hrq4), 0);

    // Reset in the middle of COMPUTE, then a fresh job.
    t0 = cyc;
    start = 1'b1;
    push_job(t0, 0, 8, 0);
    step();
    start = 1'b0;
    while (cyc < t0 + 10) step();
    chk("pre-reset feeding_en", int'(fe), 1);
    step();
    rst_n = 1'b0;
    q_wr.delete();
    q_fe.delete();
    q_out.delete();
    q_done.delete();
    #1;
    check_zero("mid reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    t0 = cyc;
    start = 1'b1;
    push_job(t0, 0, 8, 0);
    step();
    start = 1'b0;
    wait_idle("after reset");

`ifdef MATMUL_SEQ_REUSE_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    reuse_w = 1'b1;
    t0 = cyc;
    start = 1'b1;
    push_job(t0, 0, 8, 0);
    step();
    start = 1'b0;
    wait_idle("reuse forced full");
    t0 = cyc;
    start = 1'b1;
    push_job(t0, 4, 4, 0);
    step();
    start = 1'b0;
    wait_idle("reuse weights");
    reuse_w = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Parametrised control sequencer for the N×N systolic matrix-multiply unit. It requests operand elements from the host, writes them into weight/activation memory, and runs the MMU feed/compute window. It then steps through the N·N result outputs one per cycle and pulses `done`. It sits between the host interface, weight memory and the MMU, and replaces the fixed 2×2 controller.

## Interface
- `N`, 2, array dimension (N ≥ 2).
- `AW`, 3, memory address / output index width; 2^AW ≥ 2·N·N.
- `CW`, 3, compute-cycle counter width; 2^CW ≥ 3N−1.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `host_valid` in 1: host presents an element this cycle.
- `host_req_mat` out 1: controller is requesting elements.
- `wm_load_mat` out 1: write strobe to memory; equals `host_req_mat & host_valid`.
- `wm_addr` out AW: write address (current element count).
- `feeding_en` out 1: MMU feed/compute enable.
- `mmu_cycles` out CW: cycle index inside the compute window.
- `out_valid` out 1: a result element is being emitted.
- `out_idx` out AW: row-major result index, 0..N·N−1.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `reuse_w` in 1: present only with `MATMUL_SEQ_REUSE_EN`; see Configuration.

## Operation
- **States:** IDLE → LOAD → COMPUTE → OUTPUT → IDLE.
- **Element layout:** weights at addresses 0..N·N−1; activations at N·N..2N·N−1.
- **IDLE**
  - All outputs are 0 except `done`.
  - `start`=1 moves to LOAD and loads the element counter with its start address: 0 normally, N·N in reuse mode.
- **LOAD**
  - `host_req_mat`=1 for the whole state.
  - An element is accepted on each cycle with `host_valid`=1.
  - On accept: `wm_load_mat`=1 and `wm_addr`=counter; the counter then increments.
  - When `host_valid`=0 the counter holds, with no timeout.
  - The accept at address 2N·N−1 moves to COMPUTE.
- **COMPUTE**
  - `feeding_en`=1 for exactly 3N−1 cycles.
  - `mmu_cycles` counts 0..3N−2, then the state moves to OUTPUT.
- **OUTPUT**
  - `out_valid`=1 for N·N cycles.
  - `out_idx` steps 0..N·N−1.
  - After the last index the state moves to IDLE.
- **done:** registered; 1 in the first IDLE cycle after OUTPUT.
- **Counters:** all reset to 0 on leaving their state; they never wrap inside a state.
- **Boundary conditions**
  - `start` outside IDLE is ignored; no queuing.
  - `start` during the `done` cycle is accepted, since the state is already IDLE.
  - `host_valid` outside LOAD is ignored; `wm_load_mat` stays 0.
  - `rst_n` low mid-job: immediately IDLE, all outputs 0, counters 0, weights-valid flag cleared. Partial memory contents are not tracked.

## Timing
- **Reset values:** `host_req_mat`, `wm_load_mat`, `wm_addr`, `feeding_en`, `mmu_cycles`, `out_valid`, `out_idx`, `busy`, `done` are all 0.
- **Registered outputs:** `host_req_mat`, `feeding_en`, `mmu_cycles`, `out_valid`, `out_idx`, `busy` and `done` are registered.
- **Combinational outputs:** `wm_load_mat` and `wm_addr` are combinational from the registered state/counter plus `host_valid`.
- **Start latency:** `start` high in cycle t gives LOAD, `host_req_mat`=1 and `busy`=1 in cycle t+1.
- **Job latency**, with `host_valid` held high and L = number of loaded elements:
  - `done` in cycle t + 1 + L + (3N−1) + N·N.
  - N=2, full load: LOAD cycles 1–8, COMPUTE 9–13, OUTPUT 14–17, `done` in cycle 18.
- **Stalls:** each `host_valid`=0 cycle in LOAD adds exactly one cycle.

## Configuration
- **With `MATMUL_SEQ_REUSE_EN` defined**
  - The `reuse_w` port exists and is sampled with `start`.
  - An internal weights-valid flag is set when a full load completes and cleared by reset.
  - If `reuse_w`=1 and weights are valid, LOAD starts at address N·N and loads only the N·N activations.
  - If `reuse_w`=1 and weights are not valid, a full load is forced.
- **Without it:** the port and flag are absent, and every job performs the full 2N·N load.

## Test plan
- **Full job, N=2, `host_valid`=1:** `start` at cycle 0 → addresses 0..7 written in cycles 1–8; `feeding_en` high in cycles 9–13 with `mmu_cycles` 0..4; `out_idx` 0..3 in cycles 14–17; `done` only in cycle 18.
- **Host stalls, N=2:** `host_valid` low for 3 cycles after the 2nd accept → every later event shifts by 3 cycles, and `wm_addr` sequence is still 0..7 with no duplicates.
- **N=4 instance** (AW=5, CW=4): 32 writes; COMPUTE lasts 11 cycles (`mmu_cycles` 0..10); 16 outputs; `done` at cycle 60 for `start` at 0.
- **`start` while busy / back-to-back:** `start` pulsed in cycle 5 is ignored; `start` held through the `done` cycle launches a second job, with LOAD in the following cycle.
- **Reset mid-COMPUTE:** `rst_n` low in cycle 11 → all outputs 0 asynchronously; after release, a `start` runs a complete fresh job.
- **Reuse (macro defined):**
  - `reuse_w`=1 after reset → full 8-element load.
  - Next job with `reuse_w`=1 → only addresses 4..7, and `done` 10 cycles after LOAD ends for N=2 (5 COMPUTE + 4 OUTPUT + 1).
